mem_stage: RTL and testbench

- MEM stage of the 5-stage RISC-V (RV32I) pipeline, between the EX/MEM latch and MEM_WB.
- Executes loads and stores over the CPU's byte-wide memory port, one byte per handshake.
- Raises stall_req to the pipeline controller while an access is in flight.
- Passes non-memory results straight through to MEM_WB.

---
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32I MEM stage running loads/stores byte-serially over an 8-bit bus.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned H/W accesses in IDLE with a misalign_err pulse.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ex_we,
  input  logic [4:0]        ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [1:0]        ex_mem_op,
  input  logic [2:0]        ex_funct3,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_we,
  output logic [4:0]        mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall_req,
  output logic              bus_req,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_dout,
  input  logic [7:0]        bus_din,
  input  logic              bus_ack,
  output logic              misalign_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d, last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] sdata_q, sdata_d, acc_q, acc_d;
  logic [4:0]        waddr_q, waddr_d;
  logic              we_q, we_d, store_q, store_d;

  logic              is_ld, is_st, is_mem, misalign;
  logic [1:0]        last_idx;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] load_val;

  assign is_ld   = (ex_mem_op == 2'b01);
  assign is_st   = (ex_mem_op == 2'b10);
  assign is_mem  = is_ld | is_st;
  assign ex_addr = ex_wdata[ADDR_W-1:0];

  // Index of the final byte; reserved widths fall back to a full word.
  always_comb begin
    last_idx = 2'd3;
    case (ex_funct3)
      3'b000:  last_idx = 2'd0;
      3'b001:  last_idx = 2'd1;
      3'b100:  last_idx = is_ld ? 2'd0 : 2'd3;
      3'b101:  last_idx = is_ld ? 2'd1 : 2'd3;
      default: last_idx = 2'd3;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem &&
                    (((last_idx == 2'd1) && ex_addr[0]) ||
                     ((last_idx == 2'd3) && (ex_addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    load_val = acc_q;
    case (funct3_q)
      3'b000:  load_val = {{24{acc_q[7]}}, acc_q[7:0]};
      3'b100:  load_val = {24'd0, acc_q[7:0]};
      3'b001:  load_val = {{16{acc_q[15]}}, acc_q[15:0]};
      3'b101:  load_val = {16'd0, acc_q[15:0]};
      default: load_val = acc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      last_q   <= 2'd0;
      addr_q   <= '0;
      funct3_q <= 3'd0;
      sdata_q  <= '0;
      acc_q    <= '0;
      waddr_q  <= 5'd0;
      we_q     <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      sdata_q  <= sdata_d;
      acc_q    <= acc_d;
      waddr_q  <= waddr_d;
      we_q     <= we_d;
      store_q  <= store_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    sdata_d  = sdata_q;
    acc_d    = acc_q;
    waddr_d  = waddr_q;
    we_d     = we_q;
    store_d  = store_q;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (is_mem && !misalign) begin
            state_d  = ACCESS;
            cnt_d    = 2'd0;
            last_d   = last_idx;
            addr_d   = ex_addr;
            funct3_d = ex_funct3;
            sdata_d  = ex_store_data;
            acc_d    = '0;
            waddr_d  = ex_waddr;
            we_d     = ex_we;
            store_d  = is_st;
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            if (!store_q) acc_d[{cnt_q, 3'b000} +: 8] = bus_din;
            if (cnt_q == last_q) state_d = DONE;
            else                 cnt_d   = cnt_q + 2'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are forced low while rst is held, even if EX presents a memory op.
  always_comb begin
    mem_we       = 1'b0;
    mem_waddr    = 5'd0;
    mem_wdata    = '0;
    stall_req    = 1'b0;
    bus_req      = 1'b0;
    bus_rw       = 1'b0;
    bus_addr     = '0;
    bus_dout     = 8'd0;
    misalign_err = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (!is_mem) begin
            mem_we    = ex_we;
            mem_waddr = ex_waddr;
            mem_wdata = ex_wdata;
          end else if (misalign) begin
            misalign_err = 1'b1;
          end else begin
            stall_req = 1'b1;
          end
        end
        ACCESS: begin
          stall_req = 1'b1;
          bus_req   = 1'b1;
          bus_rw    = store_q;
          bus_addr  = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
          bus_dout  = store_q ? sdata_q[{cnt_q, 3'b000} +: 8] : 8'd0;
        end
        DONE: begin
          if (!store_q) begin
            mem_we    = we_q;
            mem_waddr = waddr_q;
            mem_wdata = load_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table, reset/stall sequences and random traffic for mem_stage,
// checked against a byte-array memory model; honours MEM_ALIGN_CHECK_EN when defined.
module tb_mem_stage;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata, ex_store_data;
  logic [1:0]  ex_mem_op;
  logic [2:0]  ex_funct3;
  logic        mem_we, stall_req, bus_req, bus_rw, bus_ack, misalign_err;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata, bus_addr;
  logic [7:0]  bus_dout, bus_din;

  int checks = 0;
  int errors = 0;

  logic [7:0] bus_mem [1024];
  logic [7:0] ref_mem [1024];

  mem_stage dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_funct3(ex_funct3), .ex_store_data(ex_store_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .stall_req(stall_req), .bus_req(bus_req), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
    .bus_ack(bus_ack), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] pre;
    logic [31:0] sdata;
    logic [4:0]  waddr;
    logic        we;
    int          delay;
    int          freeze;
    logic [31:0] exp_res;
    logic [31:0] exp_word;
    int          exp_stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] op, input logic [2:0] f3);
    if (op == 2'b10) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    return (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
  endfunction

  function automatic bit misaligned(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = nbytes(op, f3);
    return ALIGN_EN && (op == 2'b01 || op == 2'b10) &&
           ((n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int n;
    n = nbytes(2'b01, f3);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_mem[10'(addr + 32'(i))]) << (8 * i));
    if (f3 == 3'b000 && v >= 128)   v = v - 32'd256;
    if (f3 == 3'b001 && v >= 32768) v = v - 32'd65536;
    return v;
  endfunction

  function automatic logic [31:0] bus_word(input logic [31:0] addr);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = bus_mem[10'(addr + 32'(i))];
    return v;
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      bus_mem[10'(addr + 32'(i))] = word[8*i +: 8];
      ref_mem[10'(addr + 32'(i))] = word[8*i +: 8];
    end
  endtask

  // Called at a falling edge; returns at a falling edge with EX inputs idle.
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] waddr, input logic we,
                        input int delay, input int freeze,
                        output logic [31:0] res, output int stalls);
    int  n, k, wait_c, cyc, idx, exp_stall;
    bit  st, mop, mis, frozen, done;
    logic [31:0] exp_v;
    n   = nbytes(op, f3);
    st  = (op == 2'b10);
    mop = (op == 2'b01) || st;
    mis = misaligned(op, f3, addr);
    res = 0;
    stalls = 0;
    ex_mem_op = op; ex_funct3 = f3; ex_wdata = addr; ex_store_data = sdata;
    ex_waddr = waddr; ex_we = we;
    if (!mop || mis) begin
      bus_ack = 1'b1;
      bus_din = 8'hEE;
      #1;
      chk("nostall_stall", stall_req, 0);
      chk("nostall_bus_req", bus_req, 0);
      if (mis) begin
        chk("mis_err", misalign_err, 1);
        chk("mis_we", mem_we, 0);
      end else begin
        chk("pt_we", mem_we, we);
        chk("pt_waddr", mem_waddr, waddr);
        chk("pt_wdata", mem_wdata, addr);
        chk("pt_mis_err", misalign_err, 0);
      end
      res = mem_wdata;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("nostall_next_req", bus_req, 0);
      chk("nostall_next_stall", stall_req, 0);
      ex_mem_op = 2'b00; ex_we = 1'b0;
      return;
    end
    #1;
    chk("idle_stall", stall_req, 1);
    chk("idle_bus_req", bus_req, 0);
    chk("idle_we", mem_we, 0);
    chk("idle_mis_err", misalign_err, 0);
    stalls = 1; k = 0; wait_c = 0; frozen = 0; done = 0; cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus_ack = 1'b0;
      if (stall_req) stalls++;
      if (bus_req) begin
        chk("bus_addr", bus_addr, addr + 32'(k));
        chk("bus_rw", bus_rw, st);
        if (st && k < 4) chk("bus_dout", bus_dout, sdata[8*k +: 8]);
        chk("access_we", mem_we, 0);
        if (freeze > 0 && !frozen && k == n / 2) begin
          frozen = 1;
          rdy = 1'b0;
          for (int f = 0; f < freeze; f++) begin
            @(negedge clk);
            cyc++;
            if (stall_req) stalls++;
            chk("frz_bus_req", bus_req, 1);
            chk("frz_bus_addr", bus_addr, addr + 32'(k));
          end
          rdy = 1'b1;
        end
        if (wait_c >= delay) begin
          bus_ack = 1'b1;
          idx = int'(bus_addr[9:0]);
          if (st) bus_mem[idx] = bus_dout;
          else    bus_din = bus_mem[idx];
          k++;
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end else if (!stall_req) begin
        done  = 1;
        exp_v = st ? 32'd0 : ref_load(f3, addr);
        chk("done_bytes", k, n);
        chk("done_we", mem_we, st ? 1'b0 : we);
        chk("done_waddr", mem_waddr, st ? 5'd0 : waddr);
        chk("done_wdata", mem_wdata, exp_v);
        res = mem_wdata;
        ex_mem_op = 2'b00; ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'h5A5A_0001;
        bus_ack = 1'b1;
      end else begin
        chk("req_while_stall", bus_req, 1);
      end
    end
    chk("op_completed", done, 1);
    if (done) begin
      @(negedge clk);
      bus_ack = 1'b0;
      chk("post_stall", stall_req, 0);
      chk("post_bus_req", bus_req, 0);
      chk("post_we", mem_we, 0);
      chk("post_wdata", mem_wdata, 32'h5A5A_0001);
    end
    exp_stall = n + 1 + delay * n + freeze;
    chk("stall_cycles", stalls, exp_stall);
    if (st) begin
      for (int i = 0; i < n; i++) ref_mem[10'(addr + 32'(i))] = sdata[8*i +: 8];
      for (int i = 0; i < n; i++)
        chk("store_byte", bus_mem[10'(addr + 32'(i))], ref_mem[10'(addr + 32'(i))]);
    end
    ex_mem_op = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [15];
    logic [31:0] res;
    int          stalls;

    vecs[0]  = '{2'b00, 3'b010, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0000_1234, 32'h0, 0};
    vecs[1]  = '{2'b11, 3'b010, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd9, 1'b1, 0, 0, 32'hDEAD_BEEF, 32'h0, 0};
    vecs[2]  = '{2'b01, 3'b010, 32'h0000_0100, 32'h1234_5678, 32'h0, 5'd7, 1'b1, 0, 0, 32'h1234_5678, 32'h1234_5678, 5};
    vecs[3]  = '{2'b01, 3'b000, 32'h0000_0120, 32'h0000_0080, 32'h0, 5'd7, 1'b1, 0, 0, 32'hFFFF_FF80, 32'h0000_0080, 2};
    vecs[4]  = '{2'b01, 3'b100, 32'h0000_0124, 32'h0000_0080, 32'h0, 5'd8, 1'b1, 0, 0, 32'h0000_0080, 32'h0000_0080, 2};
    vecs[5]  = '{2'b01, 3'b001, 32'h0000_0128, 32'h0000_8001, 32'h0, 5'd9, 1'b1, 0, 0, 32'hFFFF_8001, 32'h0000_8001, 3};
    vecs[6]  = '{2'b01, 3'b101, 32'h0000_012C, 32'h0000_8001, 32'h0, 5'd10, 1'b1, 0, 0, 32'h0000_8001, 32'h0000_8001, 3};
    vecs[7]  = '{2'b10, 3'b001, 32'h0000_0200, 32'h1122_3344, 32'hAABB_CCDD, 5'd11, 1'b1, 3, 0, 32'h0, 32'h1122_CCDD, 9};
    vecs[8]  = '{2'b01, 3'b011, 32'h0000_0130, 32'hCAFE_F00D, 32'h0, 5'd12, 1'b1, 1, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 9};
    vecs[9]  = '{2'b10, 3'b000, 32'h0000_0300, 32'h0, 32'h1234_565A, 5'd13, 1'b1, 0, 0, 32'h0, 32'h0000_005A, 2};
    vecs[10] = '{2'b10, 3'b100, 32'h0000_0310, 32'h0, 32'hCAFE_BABE, 5'd14, 1'b1, 0, 0, 32'h0, 32'hCAFE_BABE, 5};
    vecs[11] = '{2'b01, 3'b010, 32'h0000_0140, 32'h8765_4321, 32'h0, 5'd15, 1'b1, 0, 4, 32'h8765_4321, 32'h8765_4321, 9};
    vecs[12] = '{2'b01, 3'b010, 32'h0000_0152, 32'h0BAD_CAFE, 32'h0, 5'd16, 1'b1, 0, 0,
                 ALIGN_EN ? 32'h0 : 32'h0BAD_CAFE, 32'h0BAD_CAFE, ALIGN_EN ? 0 : 5};
    vecs[13] = '{2'b01, 3'b101, 32'hFFFF_FFFF, 32'h0000_A55A, 32'h0, 5'd17, 1'b1, 0, 0,
                 ALIGN_EN ? 32'h0 : 32'h0000_A55A, 32'h0000_A55A, ALIGN_EN ? 0 : 3};
    vecs[14] = '{2'b01, 3'b000, 32'h0000_0160, 32'h0000_007F, 32'h0, 5'd3, 1'b0, 0, 0, 32'h0000_007F, 32'h0000_007F, 2};

    for (int i = 0; i < 1024; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end

    // Reset with a load presented: everything must still read 0.
    rst = 1'b1; rdy = 1'b1; bus_ack = 1'b0; bus_din = 8'h00;
    ex_mem_op = 2'b01; ex_funct3 = 3'b010; ex_we = 1'b1; ex_waddr = 5'd3;
    ex_wdata = 32'h0000_0040; ex_store_data = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_waddr", mem_waddr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_rw", bus_rw, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_dout", bus_dout, 0);
    chk("rst_mis_err", misalign_err, 0);
    ex_mem_op = 2'b00; ex_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      preload(vecs[i].addr, vecs[i].pre);
      run_op(vecs[i].op, vecs[i].f3, vecs[i].addr, vecs[i].sdata, vecs[i].waddr, vecs[i].we,
             vecs[i].delay, vecs[i].freeze, res, stalls);
      chk($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_stalls", i), stalls, vecs[i].exp_stall);
      chk($sformatf("vec%0d_word", i), bus_word(vecs[i].addr), vecs[i].exp_word);
    end

    // Reset after the first of four load bytes, then a clean load of the same word.
    preload(32'h40, 32'h0A0B_0C0D);
    ex_mem_op = 2'b01; ex_funct3 = 3'b010; ex_wdata = 32'h40; ex_waddr = 5'd4; ex_we = 1'b1;
    @(negedge clk);
    chk("mid_req0", bus_req, 1);
    bus_ack = 1'b1;
    bus_din = bus_mem[10'h040];
    @(negedge clk);
    bus_ack = 1'b0;
    chk("mid_addr1", bus_addr, 32'h41);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_stall", stall_req, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", bus_addr, 0);
    ex_mem_op = 2'b00; ex_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'b01, 3'b010, 32'h40, 32'h0, 5'd4, 1'b1, 0, 0, res, stalls);
    chk("after_rst_res", res, 32'h0A0B_0C0D);
    chk("after_rst_stalls", stalls, 5);

    // Random traffic against the byte-array model.
    for (int it = 0; it < 60; it++) begin
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          frz;
      op   = 2'($urandom_range(0, 3));
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                         : 32'($urandom_range(0, 1023));
      frz  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      run_op(op, f3, addr, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 2), frz,
             res, stalls);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
